// File: rtl/line_mem_ctrl.sv
// Backing-memory controller behind the L1 line cache: line fill / write-back
// over req/ack, internal 32-bit word RAM, programmable access latency.
//
// Ports:
//   clk, reset (async, active-low)
//   mem_read_req/addr  -> mem_read_data, mem_read_ack   : line fill
//   mem_write_req/addr/data -> mem_write_ack            : line write-back
//   init_we/addr/data  : idle-time word preload
//   busy               : high whenever not IDLE
module line_mem_ctrl #(
  parameter int WIDTH   = 128,
  parameter int WB      = 4,
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_req,
  input  logic [31:0]       mem_read_addr,
  output logic [WIDTH-1:0]  mem_read_data,
  output logic              mem_read_ack,
  input  logic              mem_write_req,
  input  logic [31:0]       mem_write_addr,
  input  logic [WIDTH-1:0]  mem_write_data,
  output logic              mem_write_ack,
  input  logic              init_we,
  input  logic [MEM_AW-1:0] init_addr,
  input  logic [31:0]       init_data,
  output logic              busy
);

  localparam int BEATS = WIDTH / 32;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [CW-1:0] LAT_LAST =
    CW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [MEM_AW-1:0] OFS_MASK =
    MEM_AW'((1 << (WB - 2)) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_ACK
  } state_t;

  state_t             state;
  logic               op_wr;
  logic [MEM_AW-1:0]  base;
  logic [WIDTH-1:0]   wline;
  logic [CW-1:0]      cnt;
  logic [BW-1:0]      beat;

  logic [31:0]        ram [2**MEM_AW];
  logic [MEM_AW-1:0]  ram_addr;
  logic               ram_we;
  logic [MEM_AW-1:0]  ram_wa;
  logic [31:0]        ram_wd;

  logic [MEM_AW-1:0]  rd_base;
  logic [MEM_AW-1:0]  wr_base;
  logic               any_req;
  logic               unused_addr_bits;

  // Upper bits alias; lower word-offset bits select the line base.
  assign rd_base  = mem_read_addr[MEM_AW+1:2] & ~OFS_MASK;
  assign wr_base  = mem_write_addr[MEM_AW+1:2] & ~OFS_MASK;
  assign any_req  = mem_read_req | mem_write_req;
  assign ram_addr = base + MEM_AW'(beat);

  assign unused_addr_bits = ^{mem_read_addr[31:MEM_AW+2],
                              mem_read_addr[1:0],
                              mem_write_addr[31:MEM_AW+2],
                              mem_write_addr[1:0]};

  always_comb begin
    ram_we = 1'b0;
    ram_wa = init_addr;
    ram_wd = init_data;
    if (state == S_XFER && op_wr) begin
      ram_we = 1'b1;
      ram_wa = ram_addr;
      ram_wd = wline[32*int'(beat) +: 32];
    end else if (state == S_IDLE && init_we && !any_req) begin
      ram_we = 1'b1;
    end
  end

  // RAM has no reset; the gate keeps preloads out while reset is held.
  always_ff @(posedge clk) begin
    if (ram_we && reset)
      ram[ram_wa] <= ram_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      op_wr         <= 1'b0;
      base          <= '0;
      wline         <= '0;
      cnt           <= '0;
      beat          <= '0;
      busy          <= 1'b0;
      mem_read_ack  <= 1'b0;
      mem_write_ack <= 1'b0;
      mem_read_data <= '0;
    end else begin
      mem_read_ack  <= 1'b0;
      mem_write_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt  <= '0;
          beat <= '0;
          if (any_req) begin
            busy <= 1'b1;
            unique case (1'b1)
              mem_write_req: begin
                op_wr <= 1'b1;
                base  <= wr_base;
                wline <= mem_write_data;
              end
              default: begin
                op_wr <= 1'b0;
                base  <= rd_base;
              end
            endcase
            state <= (LATENCY == 0) ? S_XFER : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == LAT_LAST)
            state <= S_XFER;
          else
            cnt <= cnt + 1'b1;
        end
        S_XFER: begin
          if (!op_wr)
            mem_read_data[32*int'(beat) +: 32] <= ram[ram_addr];
          if (beat == BEAT_LAST) begin
            state         <= S_ACK;
            mem_read_ack  <= !op_wr;
            mem_write_ack <= op_wr;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        S_ACK: begin
          // The cache still holds req on this closing edge; it is
          // ignored here, so the ack cycle also serves as the gap.
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
